fp_result_collector: RTL and testbench

- Downstream stage of the FP arithmetic core (Main).
- Consumes the core's result handshake (output_z_stb/output_z_ack) and captures output_zs or output_zd according to the active process code.
- Buffers tagged results in a small first-word-fall-through FIFO and presents them to a consumer over valid/ready.
- Backpressures the core by withholding z_ack while the FIFO is full.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_result_fifo.sv | 72 +++++++
 rtl/fp_result_collector.sv | 99 +++++++++
 tb/tb_fp_result_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared process codes, widths and collector state encoding
package fp_pkg;

  localparam logic [1:0] PROC_SINGLE_BIN   = 2'b00;
  localparam logic [1:0] PROC_SINGLE_UNARY = 2'b01;
  localparam logic [1:0] PROC_DOUBLE_BIN   = 2'b10;
  localparam logic [1:0] PROC_RSVD         = 2'b11;

  localparam int SINGLE_W = 32;
  localparam int DOUBLE_W = 64;
  localparam int FMT_W    = 2;
  localparam int ENTRY_W  = FMT_W + DOUBLE_W;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACK      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  // The reserved code falls through to the single-precision path.
  function automatic logic [DOUBLE_W-1:0] select_result(
    input logic [FMT_W-1:0]    proc,
    input logic [SINGLE_W-1:0] zs,
    input logic [DOUBLE_W-1:0] zd
  );
    if (proc == PROC_DOUBLE_BIN) begin
      return zd;
    end
    return {{(DOUBLE_W-SINGLE_W){1'b0}}, zs};
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// rtl/fp_result_fifo.sv - first-word-fall-through FIFO holding tagged results
module fp_result_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = ENTRY_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int FILL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head_data,
  output logic              full,
  output logic              empty,
  output logic [FILL_W-1:0] fill
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (fill_q == FILL_W'(DEPTH));
  assign empty     = (fill_q == '0);
  assign fill      = fill_q;
  assign head_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// rtl/fp_result_collector.sv - captures FP core results and queues them for a consumer
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               process,
  input  logic [SINGLE_W-1:0]      output_zs,
  input  logic [DOUBLE_W-1:0]      output_zd,
  input  logic                     output_z_stb,
  output logic                     output_z_ack,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DOUBLE_W-1:0]      m_data,
  output logic [1:0]               m_fmt,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         total_results
);

  logic [1:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             capture;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Full is judged on occupancy before any same-edge pop, so a pop never
  // opens room for a capture on that same edge.
  assign capture    = (state_q == ST_IDLE) && output_z_stb && !fifo_full;
  assign push_entry = {process, select_result(process, output_zs, output_zd)};

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    total_d = total_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (total_q != {CNT_W{1'b1}}) begin
            total_d = total_q + CNT_W'(1);
          end
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // Hold off until the core drops stb so one result is taken once.
        if (!output_z_stb) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      total_q <= total_d;
    end
  end

  fp_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (push_entry),
    .pop       (m_ready),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign output_z_ack  = ack_q;
  assign m_valid       = !fifo_empty;
  assign m_data        = head_entry[DOUBLE_W-1:0];
  assign m_fmt         = head_entry[ENTRY_W-1:DOUBLE_W];
  assign total_results = total_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// tb/tb_fp_result_collector.sv - directed self-checking bench for fp_result_collector
module tb_fp_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  process = 2'b00;
  logic [31:0] zs = '0;
  logic [63:0] zd = '0;
  logic        stb = 1'b0;
  logic        ack;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [1:0]  m_fmt;
  logic [2:0]  fill;
  logic [15:0] total;

  int n_tests = 0;
  int n_fail  = 0;

  fp_result_collector #(.DEPTH(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .process       (process),
    .output_zs     (zs),
    .output_zd     (zd),
    .output_z_stb  (stb),
    .output_z_ack  (ack),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_fmt         (m_fmt),
    .fill          (fill),
    .total_results (total)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one result, wait (bounded) for ack, then return the FSM to IDLE.
  task automatic offer(input logic [1:0] p, input logic [31:0] v, input string tag);
    logic seen;
    seen    = 1'b0;
    process = p;
    zs      = v;
    stb     = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = ack;
    end
    chk(tag, {63'd0, seen}, 64'd1);
    stb = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset ack", {63'd0, ack}, 64'd0);
    chk("reset m_valid", {63'd0, m_valid}, 64'd0);
    chk("reset fill", {61'd0, fill}, 64'd0);
    chk("reset total", {48'd0, total}, 64'd0);
    rst = 1'b1;
    tick();

    // single capture and ack latency
    process = 2'b00;
    zs      = 32'h3F80_0000;
    stb     = 1'b1;
    #1;
    chk("single ack before edge", {63'd0, ack}, 64'd0);
    tick();
    chk("single ack", {63'd0, ack}, 64'd1);
    chk("single m_valid", {63'd0, m_valid}, 64'd1);
    chk("single m_data", m_data, 64'h0000_0000_3F80_0000);
    chk("single m_fmt", {62'd0, m_fmt}, 64'd0);
    chk("single fill", {61'd0, fill}, 64'd1);
    chk("single total", {48'd0, total}, 64'd1);
    stb = 1'b0;
    tick();
    chk("single ack one cycle", {63'd0, ack}, 64'd0);
    tick();
    pop_one();
    chk("single pop fill", {61'd0, fill}, 64'd0);
    chk("single pop m_valid", {63'd0, m_valid}, 64'd0);

    // double capture then pop
    process = 2'b10;
    zd      = 64'h4009_21FB_5444_2D18;
    stb     = 1'b1;
    tick();
    chk("double ack", {63'd0, ack}, 64'd1);
    chk("double m_data", m_data, 64'h4009_21FB_5444_2D18);
    chk("double m_fmt", {62'd0, m_fmt}, 64'd2);
    chk("double fill", {61'd0, fill}, 64'd1);
    chk("double total", {48'd0, total}, 64'd2);
    stb = 1'b0;
    tick();
    tick();
    pop_one();
    chk("double pop fill", {61'd0, fill}, 64'd0);
    chk("double pop m_valid", {63'd0, m_valid}, 64'd0);

    // full / backpressure
    for (int v = 1; v <= 4; v++) begin
      offer(2'b01, 32'(v), "full fill ack");
    end
    chk("full fill4", {61'd0, fill}, 64'd4);
    chk("full total", {48'd0, total}, 64'd6);
    process = 2'b01;
    zs      = 32'd5;
    stb     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full fifth unacked", {63'd0, ack}, 64'd0);
    end
    chk("full fill held", {61'd0, fill}, 64'd4);
    chk("full head before pop", m_data, 64'd1);
    pop_one();
    chk("full pop edge no ack", {63'd0, ack}, 64'd0);
    chk("full pop fill", {61'd0, fill}, 64'd3);
    tick();
    chk("full fifth ack", {63'd0, ack}, 64'd1);
    chk("full fifth fill", {61'd0, fill}, 64'd4);
    chk("full fifth total", {48'd0, total}, 64'd7);
    stb = 1'b0;
    tick();
    tick();
    for (int v = 2; v <= 5; v++) begin
      chk("full order data", m_data, 64'(v));
      chk("full order fmt", {62'd0, m_fmt}, 64'd1);
      pop_one();
    end
    chk("full drained fill", {61'd0, fill}, 64'd0);
    chk("full drained m_valid", {63'd0, m_valid}, 64'd0);

    // sticky stb
    process = 2'b00;
    zs      = 32'h0000_00AA;
    stb     = 1'b1;
    tick();
    chk("sticky ack", {63'd0, ack}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sticky no reack", {63'd0, ack}, 64'd0);
    end
    chk("sticky total", {48'd0, total}, 64'd8);
    chk("sticky fill", {61'd0, fill}, 64'd1);
    stb = 1'b0;
    tick();
    pop_one();
    chk("sticky drained", {61'd0, fill}, 64'd0);

    // simultaneous push and pop, reserved code
    offer(2'b00, 32'h10, "simul ack a");
    offer(2'b00, 32'h11, "simul ack b");
    chk("simul fill2", {61'd0, fill}, 64'd2);
    chk("simul head pre", m_data, 64'h10);
    process = 2'b11;
    zs      = 32'h12;
    stb     = 1'b1;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("simul ack", {63'd0, ack}, 64'd1);
    chk("simul fill", {61'd0, fill}, 64'd2);
    chk("simul head", m_data, 64'h11);
    stb = 1'b0;
    tick();
    tick();
    chk("simul data b", m_data, 64'h11);
    chk("simul fmt b", {62'd0, m_fmt}, 64'd0);
    pop_one();
    chk("simul data rsvd", m_data, 64'h12);
    chk("simul fmt rsvd", {62'd0, m_fmt}, 64'd3);
    pop_one();
    chk("simul total", {48'd0, total}, 64'd11);

    // asynchronous reset while in ACK
    offer(2'b00, 32'h20, "areset ack a");
    offer(2'b00, 32'h21, "areset ack b");
    process = 2'b00;
    zs      = 32'h22;
    stb     = 1'b1;
    tick();
    chk("areset in ack", {63'd0, ack}, 64'd1);
    chk("areset fill3", {61'd0, fill}, 64'd3);
    chk("areset total pre", {48'd0, total}, 64'd14);
    #2;
    rst = 1'b0;
    #1;
    chk("areset ack", {63'd0, ack}, 64'd0);
    chk("areset m_valid", {63'd0, m_valid}, 64'd0);
    chk("areset fill", {61'd0, fill}, 64'd0);
    chk("areset total", {48'd0, total}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
